// File: rtl/alu_pkg.sv
// Shared types and constants for the execute-stage ALU: op encodings, multiply FSM states,
// flag bit positions and a flag-packing helper.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_MUL = 3'b010,
        ALU_SLL = 3'b011,
        ALU_XOR = 3'b101,
        ALU_SLR = 3'b111
    } alu_op_t;

    typedef enum logic {
        ST_IDLE,
        ST_MUL
    } mul_state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                              input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/execute_alu_unit_seq_multiplier.sv
// Iterative shift-add multiplier, one partial product per cycle. In vector mode every lane
// shifts and accumulates on its own, so nothing crosses a lane boundary.
module seq_multiplier
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int LANE_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             vec,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] p
);
    localparam int LANES = WIDTH / LANE_W;
    localparam int CNT_W = $clog2(WIDTH);

    mul_state_t       state, state_next;
    logic [CNT_W-1:0] cnt;
    logic             vec_q;
    logic             last;
    logic [WIDTH-1:0] a_q, b_q, acc_q;
    logic [WIDTH-1:0] acc_s, acc_next, a_next, b_next;

    logic [LANES-1:0][LANE_W-1:0] a_l, b_l, acc_l, acc_v, a_v, b_v;

    assign a_l   = a_q;
    assign b_l   = b_q;
    assign acc_l = acc_q;
    assign acc_s = acc_q + (b_q[0] ? a_q : '0);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign acc_v[l] = acc_l[l] + (b_l[l][0] ? a_l[l] : '0);
        assign a_v[l]   = a_l[l] << 1;
        assign b_v[l]   = b_l[l] >> 1;
    end

    assign acc_next = vec_q ? acc_v : acc_s;
    assign a_next   = vec_q ? a_v : (a_q << 1);
    assign b_next   = vec_q ? b_v : (b_q >> 1);
    assign last     = (cnt == (vec_q ? CNT_W'(LANE_W - 1) : CNT_W'(WIDTH - 1)));
    assign busy     = (state == ST_MUL);
    assign p        = acc_next;

    always_comb begin
        state_next = state;
        done       = 1'b0;
        case (state)
            ST_IDLE: if (start) state_next = ST_MUL;
            ST_MUL: begin
                if (last) begin
                    done       = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            vec_q <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && start) begin
                a_q   <= a;
                b_q   <= b;
                vec_q <= vec;
                acc_q <= '0;
                cnt   <= '0;
            end else if (state == ST_MUL) begin
                acc_q <= acc_next;
                a_q   <= a_next;
                b_q   <= b_next;
                cnt   <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/execute_alu_unit.sv
// Execute-stage ALU: single-cycle add/sub/shift/xor (scalar or lane-wise) with flags, plus a
// stalling iterative multiplier. All outputs are registered.
module execute_alu_unit
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int LANE_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             StartE,
    input  logic [2:0]       ALUControlE,
    input  logic             VecE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    output logic [WIDTH-1:0] ResultE,
    output logic             ValidE,
    output logic [3:0]       FlagsE,
    output logic             IllegalE,
    output logic             BusyE
);
    localparam int LANES = WIDTH / LANE_W;
    localparam int SH_W  = $clog2(WIDTH);
    localparam int LSH_W = $clog2(LANE_W);

    alu_op_t          op;
    logic             accept, is_sub, mul_start, mul_done, mul_vec;
    logic [WIDTH-1:0] b_inv, mul_p, res;
    logic [WIDTH:0]   sum_s;
    logic [3:0]       flags, mul_flags;
    logic             ill, cy, ov;

    logic [LANES-1:0][LANE_W-1:0] a_l, b_l, binv_l, sum_v, sll_v, slr_v;

    assign op        = alu_op_t'(ALUControlE);
    assign accept    = StartE && !BusyE;
    assign mul_start = accept && (op == ALU_MUL);
    assign is_sub    = (op == ALU_SUB);

    // Subtraction reuses the adder as A + ~B + 1, so C reads as "no borrow".
    assign b_inv  = is_sub ? ~SrcBE : SrcBE;
    assign sum_s  = {1'b0, SrcAE} + {1'b0, b_inv} + {{WIDTH{1'b0}}, is_sub};
    assign a_l    = SrcAE;
    assign b_l    = SrcBE;
    assign binv_l = b_inv;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign sum_v[l] = binv_l[l] + a_l[l] + {{(LANE_W-1){1'b0}}, is_sub};
        assign sll_v[l] = a_l[l] << b_l[l][LSH_W-1:0];
        assign slr_v[l] = a_l[l] >> b_l[l][LSH_W-1:0];
    end

    always_comb begin
        res = '0;
        ill = 1'b0;
        cy  = 1'b0;
        ov  = 1'b0;
        case (op)
            ALU_ADD, ALU_SUB: begin
                res = VecE ? sum_v : sum_s[WIDTH-1:0];
                cy  = sum_s[WIDTH];
                ov  = (SrcAE[WIDTH-1] == b_inv[WIDTH-1]) && (sum_s[WIDTH-1] != SrcAE[WIDTH-1]);
            end
            ALU_SLL: res = VecE ? sll_v : (SrcAE << SrcBE[SH_W-1:0]);
            ALU_SLR: res = VecE ? slr_v : (SrcAE >> SrcBE[SH_W-1:0]);
            ALU_XOR: res = SrcAE ^ SrcBE;
            ALU_MUL: res = '0;
            default: ill = 1'b1;
        endcase

        if (ill)
            flags = pack_flags(1'b0, 1'b1, 1'b0, 1'b0);
        else if (VecE)
            flags = pack_flags(1'b0, res == '0, 1'b0, 1'b0);
        else
            flags = pack_flags(res[WIDTH-1], res == '0, cy, ov);
    end

    assign mul_flags = pack_flags(!mul_vec && mul_p[WIDTH-1], mul_p == '0, 1'b0, 1'b0);

    seq_multiplier #(.WIDTH(WIDTH), .LANE_W(LANE_W)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .vec   (VecE),
        .a     (SrcAE),
        .b     (SrcBE),
        .busy  (BusyE),
        .done  (mul_done),
        .p     (mul_p)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ResultE  <= '0;
            FlagsE   <= '0;
            ValidE   <= 1'b0;
            IllegalE <= 1'b0;
            mul_vec  <= 1'b0;
        end else begin
            ValidE   <= 1'b0;
            IllegalE <= 1'b0;
            if (mul_start)
                mul_vec <= VecE;
            if (accept && op != ALU_MUL) begin
                ResultE  <= res;
                FlagsE   <= flags;
                ValidE   <= 1'b1;
                IllegalE <= ill;
            end else if (mul_done) begin
                ResultE <= mul_p;
                FlagsE  <= mul_flags;
                ValidE  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_execute_alu_unit.sv
// Bench for execute_alu_unit: table of single-cycle vectors plus multiply/reset sequences,
// with expected results queued at issue time and checked when ValidE fires.
module tb_execute_alu_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        StartE = 1'b0;
    logic [2:0]  ALUControlE = 3'b000;
    logic        VecE = 1'b0;
    logic [31:0] SrcAE = '0;
    logic [31:0] SrcBE = '0;
    logic [31:0] ResultE;
    logic        ValidE;
    logic [3:0]  FlagsE;
    logic        IllegalE;
    logic        BusyE;

    execute_alu_unit #(.WIDTH(32), .LANE_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .StartE      (StartE),
        .ALUControlE (ALUControlE),
        .VecE        (VecE),
        .SrcAE       (SrcAE),
        .SrcBE       (SrcBE),
        .ResultE     (ResultE),
        .ValidE      (ValidE),
        .FlagsE      (FlagsE),
        .IllegalE    (IllegalE),
        .BusyE       (BusyE)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [2:0]  op;
        logic        vec;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flags;
        logic        ill;
    } vec_t;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  flags;
        logic        ill;
        int          cyc;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input int id, input string what, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL t%0d %s: got %h want %h", id, what, got, exp);
        end
    endtask

    // Called on a falling edge; the result is due lat cycles later.
    task automatic issue(input logic [2:0] op, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic [3:0] fl, input logic ill,
                         input int lat, input int id);
        exp_t e;
        ALUControlE = op;
        VecE        = v;
        SrcAE       = a;
        SrcBE       = b;
        StartE      = 1'b1;
        e.res = res; e.flags = fl; e.ill = ill; e.cyc = cyc + lat; e.id = id;
        sb.push_back(e);
    endtask

    // Returns on the falling edge where ValidE is expected.
    task automatic mul_seq(input logic v, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res, input logic [3:0] fl, input int k,
                           input int id, input bit poke);
        int n;
        @(negedge clk);
        issue(3'b010, v, a, b, res, fl, 1'b0, k + 1, id);
        @(negedge clk);
        StartE = 1'b0;
        n = 0;
        while (BusyE === 1'b1 && n < 40) begin
            n++;
            if (poke && n == 3) begin
                ALUControlE = 3'b101; SrcAE = 32'h1234_5678; SrcBE = 32'h0F0F_0F0F; StartE = 1'b1;
            end
            if (poke && n == 4) StartE = 1'b0;
            @(negedge clk);
        end
        chk(id, "busy_cycles", n, k);
    endtask

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (ValidE === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: ValidE=1 at cycle %0d, want none", cyc);
            end else begin
                e = sb.pop_front();
                chk(e.id, "result", ResultE, e.res);
                chk(e.id, "flags", {28'd0, FlagsE}, {28'd0, e.flags});
                chk(e.id, "illegal", {31'd0, IllegalE}, {31'd0, e.ill});
                chk(e.id, "valid_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    vec_t tbl[17];

    initial begin
        tbl[0]  = '{3'b000, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001, 1'b0};
        tbl[1]  = '{3'b001, 1'b0, 32'h00000005, 32'h00000005, 32'h00000000, 4'b0110, 1'b0};
        tbl[2]  = '{3'b001, 1'b0, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 4'b1000, 1'b0};
        tbl[3]  = '{3'b000, 1'b1, 32'hFF01FF01, 32'h01FF01FF, 32'h00000000, 4'b0100, 1'b0};
        tbl[4]  = '{3'b011, 1'b0, 32'h00000001, 32'h00000021, 32'h00000002, 4'b0000, 1'b0};
        tbl[5]  = '{3'b111, 1'b0, 32'h80000000, 32'h0000001F, 32'h00000001, 4'b0000, 1'b0};
        tbl[6]  = '{3'b011, 1'b0, 32'hDEADBEEF, 32'h00000020, 32'hDEADBEEF, 4'b1000, 1'b0};
        tbl[7]  = '{3'b101, 1'b0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h00000000, 4'b0100, 1'b0};
        tbl[8]  = '{3'b100, 1'b0, 32'h00001234, 32'h00005678, 32'h00000000, 4'b0100, 1'b1};
        tbl[9]  = '{3'b110, 1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0100, 1'b1};
        tbl[10] = '{3'b001, 1'b1, 32'h00050A01, 32'h01030A02, 32'hFF0200FF, 4'b0000, 1'b0};
        tbl[11] = '{3'b000, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110, 1'b0};
        tbl[12] = '{3'b001, 1'b0, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011, 1'b0};
        tbl[13] = '{3'b011, 1'b1, 32'h01010101, 32'h00010207, 32'h01020480, 4'b0000, 1'b0};
        tbl[14] = '{3'b111, 1'b1, 32'h80808080, 32'h09000000, 32'h40808080, 4'b0000, 1'b0};
        tbl[15] = '{3'b101, 1'b1, 32'h0F0F0F0F, 32'hFFFFFFFF, 32'hF0F0F0F0, 4'b0000, 1'b0};
        tbl[16] = '{3'b000, 1'b1, 32'h7F7F7F7F, 32'h01010101, 32'h80808080, 4'b0000, 1'b0};

        repeat (3) @(negedge clk);
        chk(100, "rst_result", ResultE, 32'h0);
        chk(100, "rst_flags", {28'd0, FlagsE}, 32'h0);
        chk(100, "rst_valid", {31'd0, ValidE}, 32'h0);
        chk(100, "rst_illegal", {31'd0, IllegalE}, 32'h0);
        chk(100, "rst_busy", {31'd0, BusyE}, 32'h0);
        rst = 1'b0;

        // Back-to-back single-cycle ops, one per clock.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            issue(tbl[i].op, tbl[i].vec, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].flags, tbl[i].ill, 1, i);
        end
        @(negedge clk);
        StartE = 1'b0;
        repeat (3) @(negedge clk);

        // Scalar mul with an ignored StartE while busy, then an add issued in the ValidE cycle.
        mul_seq(1'b0, 32'h00010003, 32'h00000005, 32'h0005000F, 4'b0000, 32, 200, 1'b1);
        issue(3'b000, 1'b0, 32'h2, 32'h3, 32'h5, 4'b0000, 1'b0, 1, 201);
        @(negedge clk);
        StartE = 1'b0;
        mul_seq(1'b1, 32'h10FF0203, 32'h10020304, 32'h00FE060C, 4'b0000, 8, 202, 1'b0);
        @(negedge clk);
        mul_seq(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4'b0000, 32, 203, 1'b0);
        mul_seq(1'b0, 32'h40000000, 32'h00000002, 32'h80000000, 4'b1000, 32, 204, 1'b0);
        mul_seq(1'b1, 32'h02020202, 32'h80808080, 32'h00000000, 4'b0100, 8, 205, 1'b0);
        @(negedge clk);

        // Reset in the middle of a multiply: no result may appear.
        issue(3'b010, 1'b0, 32'h00000007, 32'h00000009, 32'h0, 4'b0, 1'b0, 33, 300);
        @(negedge clk);
        StartE = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        sb.delete();
        chk(300, "rst_mid_busy", {31'd0, BusyE}, 32'h0);
        chk(300, "rst_mid_valid", {31'd0, ValidE}, 32'h0);
        chk(300, "rst_mid_result", ResultE, 32'h0);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        // Machine still works after the abort.
        issue(3'b001, 1'b0, 32'h00000010, 32'h00000001, 32'h0000000F, 4'b0010, 1'b0, 1, 301);
        @(negedge clk);
        StartE = 1'b0;
        for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
        chk(400, "pending_results", sb.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
